// File: rtl/bcd_seq_converter_if.sv
// rtl/bcd_seq_converter_if.sv - binary input / packed BCD result bundle for bcd_seq_converter
interface bcd_seq_converter_if #(
   parameter int BIN_WIDTH = 16,
   parameter int DIGITS    = 4
);
   logic [BIN_WIDTH-1:0] bin_in;
   logic                 start;
   logic [4*DIGITS-1:0]  bcd_out;
   logic                 valid;
   logic                 busy;
   logic                 overflow;

   modport master (
      output bin_in, start,
      input  bcd_out, valid, busy, overflow
   );

   modport slave (
      input  bin_in, start,
      output bcd_out, valid, busy, overflow
   );
endinterface

// File: rtl/bcd_seq_converter.sv
// rtl/bcd_seq_converter.sv - sequential shift-and-add-3 binary to packed BCD converter
module bcd_seq_converter #(
   parameter int BIN_WIDTH  = 16,
   parameter int DIGITS     = 4,
   parameter bit AUTO_START = 1'b1
) (
   input logic               clk,
   input logic               reset,
   bcd_seq_converter_if.slave bus
);

   function automatic int calc_digits(input int w);
      longint unsigned m;
      int n;
      m = (64'd1 << w) - 64'd1;
      n = 1;
      while (m >= 64'd10) begin
         m = m / 64'd10;
         n = n + 1;
      end
      return n;
   endfunction

   // Scratch always holds at least one digit above the displayed ones so overflow has a home.
   localparam int SD_MIN = calc_digits(BIN_WIDTH);
   localparam int SD     = (SD_MIN > DIGITS) ? SD_MIN : DIGITS + 1;
   localparam int CNT_W  = $clog2(BIN_WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t               state_q, state_d;
   logic [BIN_WIDTH-1:0] bin_q, bin_d;
   logic [BIN_WIDTH-1:0] last_q, last_d;
   logic [4*SD-1:0]      scr_q, scr_d;
   logic [4*SD-1:0]      adj;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [4*DIGITS-1:0]  bcd_q, bcd_d;
   logic                 valid_q, valid_d;
   logic                 busy_q, busy_d;
   logic                 ovf_q, ovf_d;
   logic                 trigger;
   logic                 hi_nonzero;

   assign trigger    = AUTO_START ? (bus.bin_in != last_q) : bus.start;
   assign hi_nonzero = |scr_q[4*SD-1:4*DIGITS];

   always_comb begin
      adj = '0;
      for (int i = 0; i < SD; i++) begin
         adj[4*i +: 4] = (scr_q[4*i +: 4] >= 4'd5) ? scr_q[4*i +: 4] + 4'd3 : scr_q[4*i +: 4];
      end
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      last_d  = last_q;
      scr_d   = scr_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;
      valid_d = 1'b0;
      busy_d  = busy_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (trigger) begin
               bin_d   = bus.bin_in;
               last_d  = bus.bin_in;
               scr_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            {scr_d, bin_d} = {adj, bin_q} << 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(BIN_WIDTH - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            ovf_d   = hi_nonzero;
            bcd_d   = hi_nonzero ? {DIGITS{4'h9}} : scr_q[4*DIGITS-1:0];
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         bin_q   <= '0;
         last_q  <= '0;
         scr_q   <= '0;
         cnt_q   <= '0;
         bcd_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         last_q  <= last_d;
         scr_q   <= scr_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.bcd_out  = bcd_q;
   assign bus.valid    = valid_q;
   assign bus.busy     = busy_q;
   assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// tb/tb_bcd_seq_converter.sv - directed checks of bcd_seq_converter in manual and auto-start modes
module tb_bcd_seq_converter;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   bcd_seq_converter_if #(.BIN_WIDTH(16), .DIGITS(4)) if0 ();
   bcd_seq_converter_if #(.BIN_WIDTH(16), .DIGITS(4)) if1 ();

   bcd_seq_converter #(.BIN_WIDTH(16), .DIGITS(4), .AUTO_START(1'b0)) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (if0.slave)
   );

   bcd_seq_converter #(.BIN_WIDTH(16), .DIGITS(4), .AUTO_START(1'b1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (if1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Returns at the negedge where valid is seen; busy-high negedges before it are counted.
   task automatic wait_valid(input int sel, input int limit, output bit seen,
                             output int cycles, output int busy_cnt);
      seen     = 1'b0;
      cycles   = 0;
      busy_cnt = 0;
      while (!seen && cycles < limit) begin
         @(negedge clk);
         cycles++;
         if ((sel == 0) ? if0.valid : if1.valid) seen = 1'b1;
         else if ((sel == 0) ? if0.busy : if1.busy) busy_cnt++;
      end
   endtask

   task automatic conv0(input string tag, input logic [15:0] v,
                        input logic [15:0] exp_bcd, input logic exp_ovf);
      bit seen;
      int cyc, bc, first;
      if0.bin_in = v;
      if0.start  = 1'b1;
      @(negedge clk);
      if0.start  = 1'b0;
      first = if0.busy ? 1 : 0;
      wait_valid(0, 40, seen, cyc, bc);
      check({tag, "_valid_seen"}, 32'(seen), 32'd1);
      check({tag, "_busy_cycles"}, 32'(bc + first), 32'd17);
      check({tag, "_busy_at_valid"}, 32'(if0.busy), 32'd0);
      check({tag, "_bcd"}, 32'(if0.bcd_out), 32'(exp_bcd));
      check({tag, "_ovf"}, 32'(if0.overflow), 32'(exp_ovf));
      @(negedge clk);
      check({tag, "_valid_one_cycle"}, 32'(if0.valid), 32'd0);
   endtask

   initial begin
      bit seen;
      int cyc, bc, pulses;
      logic [15:0] got_bcd;
      n_checks   = 0;
      n_errors   = 0;
      reset      = 1'b0;
      if0.bin_in = 16'h1234;
      if0.start  = 1'b0;
      if1.bin_in = 16'h1234;
      if1.start  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_bcd0", 32'(if0.bcd_out), 32'd0);
      check("rst_valid0", 32'(if0.valid), 32'd0);
      check("rst_busy0", 32'(if0.busy), 32'd0);
      check("rst_ovf0", 32'(if0.overflow), 32'd0);
      check("rst_bcd1", 32'(if1.bcd_out), 32'd0);
      check("rst_busy1", 32'(if1.busy), 32'd0);

      if0.bin_in = 16'd0;
      if1.bin_in = 16'd0;
      reset = 1'b1;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (if1.valid || if1.busy) pulses++;
      end
      check("auto_idle_no_conv", 32'(pulses), 32'd0);

      conv0("c1234", 16'd1234, 16'h1234, 1'b0);
      if0.bin_in = 16'd4321;
      repeat (5) @(negedge clk);
      check("c1234_held", 32'(if0.bcd_out), 32'h1234);
      check("c1234_no_restart", 32'(if0.busy), 32'd0);
      conv0("c9999", 16'd9999, 16'h9999, 1'b0);
      conv0("c10000", 16'd10000, 16'h9999, 1'b1);
      conv0("c65535", 16'd65535, 16'h9999, 1'b1);
      conv0("c0", 16'd0, 16'h0000, 1'b0);
      conv0("c807", 16'd807, 16'h0807, 1'b0);

      // Auto-start: value changes mid-conversion and is picked up in the valid cycle.
      if1.bin_in = 16'd5;
      repeat (3) @(negedge clk);
      if1.bin_in = 16'd42;
      wait_valid(1, 40, seen, cyc, bc);
      check("auto_first_seen", 32'(seen), 32'd1);
      check("auto_first_bcd", 32'(if1.bcd_out), 32'h0005);
      @(negedge clk);
      check("auto_restart_busy", 32'(if1.busy), 32'd1);
      check("auto_restart_valid_low", 32'(if1.valid), 32'd0);
      wait_valid(1, 40, seen, cyc, bc);
      check("auto_second_seen", 32'(seen), 32'd1);
      check("auto_second_gap", 32'(cyc + 1), 32'd18);
      check("auto_second_bcd", 32'(if1.bcd_out), 32'h0042);

      // Asynchronous reset in the middle of converting 500.
      if0.bin_in = 16'd65535;
      if0.start  = 1'b1;
      @(negedge clk);
      if0.start  = 1'b0;
      wait_valid(0, 40, seen, cyc, bc);
      @(negedge clk);
      if0.bin_in = 16'd500;
      if0.start  = 1'b1;
      @(negedge clk);
      if0.start  = 1'b0;
      repeat (7) @(negedge clk);
      check("mid_busy_before_rst", 32'(if0.busy), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("async_rst_bcd", 32'(if0.bcd_out), 32'd0);
      check("async_rst_busy", 32'(if0.busy), 32'd0);
      check("async_rst_ovf", 32'(if0.overflow), 32'd0);
      if1.bin_in = 16'd0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (if0.valid || if0.busy) pulses++;
      end
      check("rst_abort_no_valid", 32'(pulses), 32'd0);
      conv0("c500", 16'd500, 16'h0500, 1'b0);

      // A second start while busy must be ignored.
      if0.bin_in = 16'd777;
      if0.start  = 1'b1;
      @(negedge clk);
      if0.start  = 1'b0;
      repeat (3) @(negedge clk);
      if0.bin_in = 16'd321;
      if0.start  = 1'b1;
      @(negedge clk);
      if0.start  = 1'b0;
      pulses  = 0;
      got_bcd = 16'hffff;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (if0.valid) begin
            pulses++;
            got_bcd = if0.bcd_out;
         end
      end
      check("busy_start_pulses", 32'(pulses), 32'd1);
      check("busy_start_bcd", 32'(got_bcd), 32'h0777);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
